// File: rtl/ula_pkg.sv
// ula_pkg: opcode encodings and shift saturation limit shared by the ALU files
package ula_pkg;
  localparam logic [3:0] OP_AND  = 4'b0000;
  localparam logic [3:0] OP_OR   = 4'b0001;
  localparam logic [3:0] OP_NOT  = 4'b0010;
  localparam logic [3:0] OP_NAND = 4'b0011;
  localparam logic [3:0] OP_ADD  = 4'b0100;
  localparam logic [3:0] OP_SUB  = 4'b0101;
  localparam logic [3:0] OP_LSL  = 4'b0110;
  localparam logic [3:0] OP_LSR  = 4'b0111;
  localparam logic [3:0] OP_NOR  = 4'b1000;
  localparam logic [3:0] OP_XOR  = 4'b1001;
  localparam logic [2:0] SHIFT_MAX = 3'd4;
endpackage

// File: rtl/ula_core_comb.sv
// ula_core_comb: combinational 4-bit ALU producing result and C/V/Z/N flags
module ula_core_comb
  import ula_pkg::*;
(
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic [3:0] op,
  output logic [3:0] r,
  output logic       c,
  output logic       v,
  output logic       z,
  output logic       n
);
  logic [4:0] sum, diff;
  logic [2:0] sh;
  assign sum  = {1'b0, a} + {1'b0, b};
  assign diff = {1'b0, a} - {1'b0, b};
  // shift amounts of 4 or more clear the operand entirely
  assign sh = (b[2:0] > SHIFT_MAX) ? SHIFT_MAX : b[2:0];
  always_comb begin
    r = 4'b0000;
    c = 1'b0;
    v = 1'b0;
    case (op)
      OP_AND:  r = a & b;
      OP_OR:   r = a | b;
      OP_NOT:  r = ~a;
      OP_NAND: r = ~(a & b);
      OP_ADD: begin
        r = sum[3:0];
        c = sum[4];
        v = (a[3] == b[3]) & (sum[3] != a[3]);
      end
      OP_SUB: begin
        r = diff[3:0];
        c = ~diff[4];
        v = (a[3] != b[3]) & (diff[3] != a[3]);
      end
      OP_LSL:  r = a << sh;
      OP_LSR:  r = a >> sh;
      OP_NOR:  r = ~(a | b);
      OP_XOR:  r = a ^ b;
      default: r = 4'b0000;
    endcase
  end
  assign z = (r == 4'b0000);
  assign n = r[3];
endmodule

// File: rtl/ula_lsl_lsr_mod_3.sv
// ula_lsl_lsr_mod_3: 4-bit ALU with result and flags registered one cycle after operands
module ula_lsl_lsr_mod_3
  import ula_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] a_in,
  input  logic [3:0] b_in,
  input  logic [3:0] op_sel,
  output logic [3:0] resultado_out,
  output logic       flag_c,
  output logic       flag_v,
  output logic       flag_z,
  output logic       flag_n
);
  logic [3:0] r;
  logic       c, v, z, n;
  ula_core_comb u_core (
    .a  (a_in),
    .b  (b_in),
    .op (op_sel),
    .r  (r),
    .c  (c),
    .v  (v),
    .z  (z),
    .n  (n)
  );
  // reset state mirrors a zero result, hence Z set
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      resultado_out <= 4'b0000;
      flag_c        <= 1'b0;
      flag_v        <= 1'b0;
      flag_z        <= 1'b1;
      flag_n        <= 1'b0;
    end else begin
      resultado_out <= r;
      flag_c        <= c;
      flag_v        <= v;
      flag_z        <= z;
      flag_n        <= n;
    end
  end
endmodule

// File: tb/tb_ula_lsl_lsr_mod_3.sv
// tb_ula_lsl_lsr_mod_3: directed and exhaustive checks of the registered ALU
module tb_ula_lsl_lsr_mod_3;
  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] a_in, b_in, op_sel;
  logic [3:0] resultado_out;
  logic       flag_c, flag_v, flag_z, flag_n;
  logic [7:0] obs;
  int         checks = 0;
  int         failures = 0;
  ula_lsl_lsr_mod_3 dut (
    .clk           (clk),
    .rst           (rst),
    .a_in          (a_in),
    .b_in          (b_in),
    .op_sel        (op_sel),
    .resultado_out (resultado_out),
    .flag_c        (flag_c),
    .flag_v        (flag_v),
    .flag_z        (flag_z),
    .flag_n        (flag_n)
  );
  always #5 clk = ~clk;
  assign obs = {resultado_out, flag_c, flag_v, flag_z, flag_n};
  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got={r,c,v,z,n}=%b expected=%b", tag, got, exp);
    end
  endtask
  // arithmetic-style reference, packed as {r[3:0], c, v, z, n}
  function automatic logic [7:0] model(input logic [3:0] op, input logic [3:0] a, input logic [3:0] b);
    int ia, ib, sa, sb, s, sh;
    logic [3:0] r;
    logic c, v;
    ia = int'(a);
    ib = int'(b);
    sa = a[3] ? ia - 16 : ia;
    sb = b[3] ? ib - 16 : ib;
    sh = ib % 8;
    if (sh > 4) sh = 4;
    r = 4'b0000;
    c = 1'b0;
    v = 1'b0;
    case (op)
      4'd0: r = a & b;
      4'd1: r = a | b;
      4'd2: r = ~a;
      4'd3: r = ~(a & b);
      4'd4: begin
        s = ia + ib;
        r = 4'(s);
        c = s > 15;
        v = (sa + sb > 7) || (sa + sb < -8);
      end
      4'd5: begin
        s = ia - ib;
        r = 4'(s);
        c = ia >= ib;
        v = (sa - sb > 7) || (sa - sb < -8);
      end
      4'd6: r = 4'(ia * (2 ** sh));
      4'd7: r = 4'(ia / (2 ** sh));
      4'd8: r = ~(a | b);
      4'd9: r = a ^ b;
      default: r = 4'b0000;
    endcase
    return {r, c, v, r == 4'b0000, r[3]};
  endfunction
  task automatic vec(input string tag, input logic [3:0] op, input logic [3:0] a, input logic [3:0] b,
                     input logic [7:0] exp);
    @(negedge clk);
    op_sel = op;
    a_in   = a;
    b_in   = b;
    @(posedge clk);
    #1;
    check(tag, obs, exp);
  endtask
  initial begin
    rst    = 1'b1;
    a_in   = 4'h7;
    b_in   = 4'h9;
    op_sel = 4'h4;
    #2;
    check("reset_async", obs, 8'h02);
    @(posedge clk);
    #1;
    check("reset_hold", obs, 8'h02);
    @(negedge clk);
    rst = 1'b0;
    vec("add_7_1",   4'h4, 4'h7, 4'h1, 8'h85);
    vec("add_f_1",   4'h4, 4'hF, 4'h1, 8'h0A);
    vec("sub_3_5",   4'h5, 4'h3, 4'h5, 8'hE1);
    vec("sub_8_1",   4'h5, 4'h8, 4'h1, 8'h7C);
    vec("sub_5_5",   4'h5, 4'h5, 4'h5, 8'h0A);
    vec("lsr_8_b",   4'h7, 4'h8, 4'hB, 8'h10);
    vec("lsl_3_d",   4'h6, 4'h3, 4'hD, 8'h02);
    vec("nor",       4'h8, 4'hA, 4'h5, 8'h02);
    vec("xor",       4'h9, 4'hC, 4'hA, 8'h60);
    vec("nand",      4'h3, 4'hF, 4'hF, 8'h02);
    vec("not_0",     4'h2, 4'h0, 4'h6, 8'hF1);
    vec("unused_f",  4'hF, 4'h7, 4'h9, 8'h02);
    vec("lsl_3_2",   4'h6, 4'h3, 4'h2, 8'hC1);
    // assert reset between edges while 1100 is registered
    @(negedge clk);
    op_sel = 4'h1;
    a_in   = 4'h5;
    b_in   = 4'hA;
    rst    = 1'b1;
    #1;
    check("rst_mid_async", obs, 8'h02);
    @(posedge clk);
    #1;
    check("rst_mid_hold", obs, 8'h02);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_release_wait", obs, 8'h02);
    @(posedge clk);
    #1;
    check("rst_release_update", obs, 8'hF1);
    for (int o = 0; o < 16; o++)
      for (int a = 0; a < 16; a++)
        for (int b = 0; b < 16; b++) begin
          @(negedge clk);
          op_sel = 4'(o);
          a_in   = 4'(a);
          b_in   = 4'(b);
          @(posedge clk);
          #1;
          check($sformatf("exh op=%h a=%h b=%h", o, a, b), obs, model(4'(o), 4'(a), 4'(b)));
        end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
